// File: rtl/axi_pkg.sv
// AXI4 encodings and channel bundle types shared by IOMMU bus masters.
package axi_pkg;

    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_ADDR_W = 64;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_8B = 3'd3;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic                  user;
    } aw_chan_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic                  last;
        logic                  user;
    } w_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
        logic                user;
    } b_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic                  user;
    } ar_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic                  user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;

endpackage

// File: rtl/rv_iommu_pkg.sv
// IOMMU-wide constants: AXI IDs the bus interface routes B responses by.
package rv_iommu_pkg;

    localparam int unsigned CQ_AXI_ID     = 0;
    localparam int unsigned FQ_AXI_ID     = 1;
    localparam int unsigned MSI_IG_AXI_ID = 2;

endpackage

// File: rtl/rv_iommu_ds_wr_master.sv
// Single-job AXI4 write-burst master (AW -> W -> B) for IOMMU write clients.
module rv_iommu_ds_wr_master
    import axi_pkg::*;
    import rv_iommu_pkg::*;
#(
    parameter int unsigned AXI_ID  = FQ_AXI_ID,
    parameter int unsigned N_BEATS = 4,
    parameter int unsigned ADDR_W  = 56,
    parameter type axi_req_t = axi_pkg::axi_req_t,
    parameter type axi_rsp_t = axi_pkg::axi_rsp_t,
    localparam int unsigned LEN_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_W-1:0]       req_addr_i,
    input  logic [LEN_W-1:0]        req_len_i,
    input  logic [64*N_BEATS-1:0]   req_data_i,
    input  logic [7:0]              req_strb_i,
    output logic                    done_o,
    output logic                    error_o,
    output axi_req_t                mem_req_o,
    input  axi_rsp_t                mem_resp_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B
    } state_e;

    state_e                     state_q, state_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [LEN_W-1:0]           cnt_q, cnt_d;
    logic [N_BEATS-1:0][63:0]   data_q, data_d;
    logic [7:0]                 strb_q, strb_d;
    logic                       done_q, done_d;
    logic                       error_q, error_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        strb_d  = strb_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = {req_addr_i[ADDR_W-1:3], 3'b000};
                    len_d   = req_len_i;
                    data_d  = req_data_i;
                    strb_d  = req_strb_i;
                    cnt_d   = '0;
                    state_d = S_AW;
                end
            end
            S_AW: begin
                if (mem_resp_i.aw_ready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                if (mem_resp_i.w_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_q) begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                if (mem_resp_i.b_valid) begin
                    state_d = S_IDLE;
                    // OKAY and EXOKAY share resp[1] == 0
                    if (mem_resp_i.b.resp[1]) begin
                        error_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Payloads are zeroed outside their channel's state so idle buses stay quiet
    always_comb begin
        mem_req_o = '0;
        mem_req_o.aw_valid = (state_q == S_AW);
        mem_req_o.w_valid  = (state_q == S_W);
        mem_req_o.b_ready  = (state_q == S_B);
        if (state_q == S_AW) begin
            mem_req_o.aw.id    = AXI_ID_W'(AXI_ID);
            mem_req_o.aw.addr  = AXI_ADDR_W'(addr_q);
            mem_req_o.aw.len   = 8'(len_q);
            mem_req_o.aw.size  = SIZE_8B;
            mem_req_o.aw.burst = BURST_INCR;
        end
        if (state_q == S_W) begin
            mem_req_o.w.data = data_q[cnt_q];
            mem_req_o.w.strb = strb_q;
            mem_req_o.w.last = (cnt_q == len_q);
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign done_o      = done_q;
    assign error_o     = error_q;

    logic unused_in;
    assign unused_in = ^{mem_resp_i, req_addr_i[2:0]};

endmodule

// File: tb/tb_rv_iommu_ds_wr_master.sv
// Randomized bench: job-level reference model plus AXI slave with backpressure.
module tb_rv_iommu_ds_wr_master;
    import axi_pkg::*;
    import rv_iommu_pkg::*;

    typedef struct packed {
        logic [55:0]       addr;
        logic [1:0]        len;
        logic [3:0][63:0]  data;
        logic [7:0]        strb;
        logic [1:0]        resp;
        logic [7:0]        bdly;
    } job_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [55:0]  req_addr = '0;
    logic [1:0]   req_len = '0;
    logic [255:0] req_data = '0;
    logic [7:0]   req_strb = '0;
    logic         done, error;
    axi_req_t     mreq;
    axi_rsp_t     mrsp = '0;

    rv_iommu_ds_wr_master #(
        .AXI_ID    (FQ_AXI_ID),
        .N_BEATS   (4),
        .ADDR_W    (56),
        .axi_req_t (axi_req_t),
        .axi_rsp_t (axi_rsp_t)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_len_i   (req_len),
        .req_data_i  (req_data),
        .req_strb_i  (req_strb),
        .done_o      (done),
        .error_o     (error),
        .mem_req_o   (mreq),
        .mem_resp_i  (mrsp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    job_t pend[$];
    job_t jq[$];
    int   aw_p = 100, w_p = 100;
    int   cyc = 0, hs_cyc = 0, aw_hs_cyc = 0;
    int   n_done = 0, beat = 0, b_cnt = 0;
    bit   busy = 0, aw_done = 0, b_wait = 0;
    bit   exp_done = 0, exp_err = 0;
    bit   aw_stall = 0, w_stall = 0, aw_vp = 0, w_vp = 0;
    aw_chan_t aw_prev;
    w_chan_t  w_prev;

    always @(negedge clk) begin
        if (!rst_n) begin
            jq.delete();
            busy = 0; aw_done = 0; b_wait = 0; beat = 0;
            exp_done = 0; exp_err = 0;
            aw_stall = 0; w_stall = 0; aw_vp = 0; w_vp = 0;
            mrsp = '0;
            req_valid = 1'b0;
        end else begin
            cyc++;
            check("done", done, exp_done);
            check("error", error, exp_err);
            exp_done = 0; exp_err = 0;
            check("req_ready", req_ready, !busy);
            check("b_ready", mreq.b_ready, b_wait);
            check("ar_idle", {mreq.ar_valid, mreq.r_ready}, 0);
            if (aw_stall)
                check("aw_hold", {mreq.aw_valid, mreq.aw === aw_prev}, 2'b11);
            if (w_stall)
                check("w_hold", {mreq.w_valid, mreq.w === w_prev}, 2'b11);
            if (mreq.aw_valid && !aw_vp)
                check("aw_lat", cyc - hs_cyc, 1);
            if (mreq.w_valid)
                check("w_after_aw", aw_done, 1);
            if (mreq.w_valid && !w_vp)
                check("w_lat", cyc - aw_hs_cyc, 1);

            // B channel first so b_valid never precedes the last W beat
            mrsp.b_valid = 1'b0;
            if (b_wait && jq.size() > 0) begin
                if (b_cnt == 0) begin
                    mrsp.b_valid = 1'b1;
                    mrsp.b.id    = AXI_ID_W'(FQ_AXI_ID);
                    mrsp.b.resp  = jq[0].resp;
                    if (mreq.b_ready) begin
                        exp_done = (jq[0].resp == RESP_OKAY) ||
                                   (jq[0].resp == RESP_EXOKAY);
                        exp_err  = !exp_done;
                        void'(jq.pop_front());
                        b_wait = 0; busy = 0; aw_done = 0; beat = 0;
                        n_done++;
                    end
                end else begin
                    b_cnt--;
                end
            end

            mrsp.aw_ready = ($urandom_range(99) < aw_p);
            mrsp.w_ready  = ($urandom_range(99) < w_p);

            if (mreq.aw_valid && mrsp.aw_ready) begin
                check("aw_job", jq.size(), 1);
                if (jq.size() > 0) begin
                    check("aw_id", mreq.aw.id, FQ_AXI_ID);
                    check("aw_addr", mreq.aw.addr, {jq[0].addr[55:3], 3'b000});
                    check("aw_len", mreq.aw.len, jq[0].len);
                    check("aw_size", mreq.aw.size, 3);
                    check("aw_burst", mreq.aw.burst, BURST_INCR);
                    check("aw_misc", {mreq.aw.lock, mreq.aw.cache,
                        mreq.aw.prot, mreq.aw.qos, mreq.aw.region,
                        mreq.aw.atop, mreq.aw.user}, 0);
                end
                aw_done = 1; aw_hs_cyc = cyc;
            end

            if (mreq.w_valid && mrsp.w_ready && jq.size() > 0) begin
                check("w_data", mreq.w.data, jq[0].data[beat]);
                check("w_strb", mreq.w.strb, jq[0].strb);
                check("w_last", mreq.w.last, beat == int'(jq[0].len));
                check("w_user", mreq.w.user, 0);
                if (beat == int'(jq[0].len)) begin
                    b_wait = 1;
                    b_cnt  = int'(jq[0].bdly);
                end
                beat++;
            end

            aw_stall = mreq.aw_valid && !mrsp.aw_ready;
            w_stall  = mreq.w_valid && !mrsp.w_ready;
            aw_prev  = mreq.aw;
            w_prev   = mreq.w;
            aw_vp    = mreq.aw_valid;
            w_vp     = mreq.w_valid;

            req_valid = (pend.size() > 0);
            if (pend.size() > 0) begin
                req_addr = pend[0].addr;
                req_len  = pend[0].len;
                req_data = pend[0].data;
                req_strb = pend[0].strb;
                if (req_ready) begin
                    jq.push_back(pend.pop_front());
                    busy = 1; hs_cyc = cyc;
                end
            end
        end
    end

    function automatic job_t rnd_job();
        job_t j;
        j.addr = {24'($urandom), 32'($urandom)};
        j.len  = 2'($urandom_range(3));
        for (int k = 0; k < 4; k++) j.data[k] = {32'($urandom), 32'($urandom)};
        j.strb = 8'($urandom);
        j.resp = 2'($urandom);
        j.bdly = 8'($urandom_range(3));
        return j;
    endfunction

    task automatic wait_jobs(int target);
        for (int i = 0; i < 5000 && n_done < target; i++) @(negedge clk);
        check("jobs_done", n_done, target);
    endtask

    task automatic check_idle(string tag);
        check({tag, "_valids"}, {mreq.aw_valid, mreq.w_valid, mreq.b_ready,
            mreq.ar_valid, mreq.r_ready}, 0);
        check({tag, "_ready"}, req_ready, 1);
        check({tag, "_pulses"}, {done, error}, 0);
        check({tag, "_aw_zero"}, mreq.aw === '0, 1);
        check({tag, "_w_zero"}, mreq.w === '0, 1);
    endtask

    initial begin
        job_t j;
        repeat (3) @(posedge clk);
        #1 check_idle("rst");
        @(posedge clk);
        #2 rst_n = 1'b1;

        j.addr = 56'h8000_1020; j.len = 2'd3; j.strb = 8'hFF;
        j.data[0] = 64'h1111_1111_1111_1111;
        j.data[1] = 64'h2222_2222_2222_2222;
        j.data[2] = 64'h3333_3333_3333_3333;
        j.data[3] = 64'h4444_4444_4444_4444;
        j.resp = RESP_OKAY; j.bdly = 8'd0;
        pend.push_back(j);
        wait_jobs(1);

        j.addr = 56'h2800_0004; j.len = 2'd0; j.strb = 8'hF0;
        j.data[0] = 64'hDEAD_BEEF_0BAD_F00D;
        j.resp = RESP_SLVERR;
        pend.push_back(j);
        wait_jobs(2);

        aw_p = 50; w_p = 50;
        for (int i = 0; i < 30; i++) pend.push_back(rnd_job());
        wait_jobs(32);

        aw_p = 100; w_p = 100;
        for (int i = 0; i < 2; i++) begin
            j = rnd_job();
            j.bdly = 8'd20;
            pend.push_back(j);
        end
        wait_jobs(34);

        j = rnd_job();
        j.len = 2'd3; j.bdly = 8'd0;
        pend.push_back(j);
        for (int i = 0; i < 200 && beat != 2; i++) @(negedge clk);
        check("reach_beat2", beat, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle("midrst");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("post_rst_ready", req_ready, 1);

        j = rnd_job();
        j.resp = RESP_EXOKAY;
        pend.push_back(j);
        wait_jobs(35);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
